// File: rtl/conv_frame_writer.sv
// Consumer end of the convolution stream: drops warm-up and row-wrap results
// from the free-running filter output and writes the valid pixels row-major.
module conv_frame_writer #(
    parameter int WORD_SIZE    = 8,
    parameter int ROW_SIZE     = 10,
    parameter int COL_SIZE     = 10,
    parameter int PRIME_CYCLES = 2*ROW_SIZE+2+3,
    parameter int ADDR_W       = $clog2((ROW_SIZE-2)*(COL_SIZE-2))
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WORD_SIZE-1:0] in_pixel,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [WORD_SIZE-1:0] wr_data,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 start_err
);

    localparam int PC_W = $clog2(PRIME_CYCLES+1);
    localparam int R_W  = $clog2(COL_SIZE);
    localparam int C_W  = $clog2(ROW_SIZE);

    localparam logic [PC_W-1:0] PC_MAX  = PC_W'(PRIME_CYCLES);
    localparam logic [R_W-1:0]  FIRST_R = R_W'(2);
    localparam logic [C_W-1:0]  FIRST_C = C_W'(2);
    localparam logic [R_W-1:0]  LAST_R  = R_W'(COL_SIZE-1);
    localparam logic [C_W-1:0]  LAST_C  = C_W'(ROW_SIZE-1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRIME   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]      state;
    logic [1:0]      next_state;
    logic [PC_W-1:0] prime_cnt;
    logic [R_W-1:0]  row;
    logic [C_W-1:0]  col;
    logic [ADDR_W-1:0] wr_cnt;

    logic sampling;
    logic pix_valid;
    logic last_pix;
    logic accept;

    // The final priming cycle doubles as capture index 0.
    assign sampling  = (state == CAPTURE) || ((state == PRIME) && (prime_cnt == PC_MAX));
    assign pix_valid = sampling && (col >= FIRST_C) && !abort;
    assign last_pix  = sampling && (row == LAST_R) && (col == LAST_C);
    assign accept    = start && !abort && ((state == IDLE) || (state == DONE));

    always_comb begin
        next_state = state;
        if (abort && (state != IDLE)) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) next_state = PRIME;
                PRIME:   if (sampling) next_state = last_pix ? DONE : CAPTURE;
                CAPTURE: if (last_pix) next_state = DONE;
                DONE:    next_state = accept ? PRIME : IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Row/column track the window's bottom-right corner without a divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prime_cnt <= '0;
            row       <= '0;
            col       <= '0;
            wr_cnt    <= '0;
        end else if (abort) begin
            prime_cnt <= '0;
            row       <= '0;
            col       <= '0;
            wr_cnt    <= '0;
        end else if (accept) begin
            prime_cnt <= PC_W'(1);
            row       <= FIRST_R;
            col       <= FIRST_C;
            wr_cnt    <= '0;
        end else begin
            if ((state == PRIME) && !sampling) begin
                prime_cnt <= prime_cnt + PC_W'(1);
            end
            if (sampling) begin
                if (col == LAST_C) begin
                    col <= '0;
                    row <= row + R_W'(1);
                end else begin
                    col <= col + C_W'(1);
                end
            end
            if (pix_valid) begin
                wr_cnt <= wr_cnt + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            start_err  <= 1'b0;
        end else begin
            wr_en <= pix_valid;
            if (pix_valid) begin
                wr_addr <= wr_cnt;
                wr_data <= in_pixel;
            end
            frame_done <= (state == DONE) && !abort;
            // Busy stays up through the frame_done cycle.
            busy       <= (next_state != IDLE) || ((state == DONE) && !abort);
            start_err  <= start && !abort && ((state == PRIME) || (state == CAPTURE));
        end
    end

endmodule

// File: tb/tb_conv_frame_writer.sv
// Scoreboard bench for conv_frame_writer: driver pushes expected writes,
// completion pulses and busy windows; a negedge monitor pops and compares.
module tb_conv_frame_writer;

    localparam int W   = 8;
    localparam int AW  = 6;
    localparam int R   = 10;
    localparam int C   = 10;
    localparam int PC  = 25;
    localparam int NO  = R - 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  in_pixel = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          busy;
    logic          frame_done;
    logic          start_err;

    conv_frame_writer #(
        .WORD_SIZE(W), .ROW_SIZE(R), .COL_SIZE(C), .PRIME_CYCLES(PC), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .in_pixel(in_pixel),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .frame_done(frame_done), .start_err(start_err)
    );

    always #5 clk = ~clk;

    int gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    int checks = 0;
    int failures = 0;
    int wr_seen = 0;

    // {cycle[31:0], addr[5:0], data[7:0]}
    logic [45:0] exp_q[$];
    int done_q[$];
    int err_q[$];
    int busy_lo_q[$];
    int busy_hi_q[$];

    logic [7:0] img[R][C];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, gcyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, gcyc);
    endtask

    // 8-neighbour Laplacian, magnitude saturated to 8 bits; (r0,c0) is the window top-left.
    function automatic logic [7:0] filt(input int r0, input int c0);
        int s;
        s = 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                if (dr == 1 && dc == 1) s += 8 * int'(img[r0+dr][c0+dc]);
                else                    s -= int'(img[r0+dr][c0+dc]);
        if (s < 0) s = -s;
        if (s > 255) s = 255;
        return 8'(s);
    endfunction

    // Filter output stream: junk where the window is not fully inside one frame row band.
    function automatic logic [7:0] pix(input int mode, input int k);
        int p;
        if (mode == 0) return 8'(k);
        p = k - (PC - (2*R + 2));
        if (p >= 0 && p < R*C && (p / R) >= 2 && (p % R) >= 2)
            return filt(p / R - 2, p % R - 2);
        return 8'hAA;
    endfunction

    task automatic push_busy(input int lo, input int hi);
        if (busy_hi_q.size() > 0 && lo <= busy_hi_q[busy_hi_q.size()-1] + 1)
            busy_hi_q[busy_hi_q.size()-1] = hi;
        else begin
            busy_lo_q.push_back(lo);
            busy_hi_q.push_back(hi);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_wr_en"},      32'(wr_en),      32'd0);
        check({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
        check({tag, "_wr_data"},    32'(wr_data),    32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_start_err"},  32'(start_err),  32'd0);
    endtask

    // One frame: start at local cycle 0; optional second start, abort, async reset (-1 = none).
    task automatic run(input int mode, input int ncyc, input int start2_at,
                       input int abort_at, input int rst_at);
        int base, last_out, busy_hi, j, outc;
        logic [7:0] d;
        @(posedge clk); #1;
        base = gcyc;
        last_out = 1000;
        busy_hi = PC + R*(C-2) - 3 + 2;
        if (abort_at >= 0) begin last_out = abort_at; busy_hi = abort_at; end
        if (rst_at >= 0)   begin last_out = rst_at - 1; busy_hi = rst_at - 1; end
        for (int orow = 0; orow < NO; orow++) begin
            for (int ocol = 0; ocol < NO; ocol++) begin
                j = R*orow + ocol;
                outc = PC + 1 + j;
                d = (mode == 0) ? 8'(PC + j) : filt(orow, ocol);
                if (outc <= last_out)
                    exp_q.push_back({32'(base + outc), 6'(orow*NO + ocol), d});
            end
        end
        if (abort_at < 0 && rst_at < 0) done_q.push_back(base + PC + R*(C-2) - 3 + 2);
        if (start2_at > 0) err_q.push_back(base + start2_at + 1);
        push_busy(base + 1, base + busy_hi);
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            start    = (k == 0) || (k == start2_at);
            abort    = (k == abort_at);
            in_pixel = pix(mode, k);
            if (k == rst_at) begin
                #2 rst = 1'b1;
                #1 check_zero_outputs("midreset");
            end
            if (rst_at >= 0 && k == rst_at + 1) #2 rst = 1'b0;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [45:0] e;
        while (exp_q.size() > 0 && int'(exp_q[0][45:14]) < gcyc) begin
            e = exp_q.pop_front();
            fail_now($sformatf("missing_write addr=%0d data=%0d due=%0d", e[13:8], e[7:0], int'(e[45:14])));
        end
        if (wr_en) begin
            wr_seen++;
            if (exp_q.size() > 0 && int'(exp_q[0][45:14]) == gcyc) begin
                e = exp_q.pop_front();
                check("write_addr_data", 32'({wr_addr, wr_data}), 32'(e[13:0]));
            end else begin
                fail_now($sformatf("unexpected_write addr=%0d data=%0d", wr_addr, wr_data));
            end
        end
        while (done_q.size() > 0 && done_q[0] < gcyc) begin
            fail_now($sformatf("missing_frame_done due=%0d", done_q[0]));
            void'(done_q.pop_front());
        end
        if (frame_done) begin
            if (done_q.size() > 0 && done_q[0] == gcyc) begin
                void'(done_q.pop_front());
                check("frame_done", 32'(frame_done), 32'd1);
            end else fail_now("unexpected_frame_done");
        end
        while (err_q.size() > 0 && err_q[0] < gcyc) begin
            fail_now($sformatf("missing_start_err due=%0d", err_q[0]));
            void'(err_q.pop_front());
        end
        if (start_err) begin
            if (err_q.size() > 0 && err_q[0] == gcyc) begin
                void'(err_q.pop_front());
                check("start_err", 32'(start_err), 32'd1);
            end else fail_now("unexpected_start_err");
        end
        while (busy_hi_q.size() > 0 && busy_hi_q[0] < gcyc) begin
            void'(busy_lo_q.pop_front());
            void'(busy_hi_q.pop_front());
        end
        check("busy", 32'(busy),
              32'(busy_lo_q.size() > 0 && busy_lo_q[0] <= gcyc && gcyc <= busy_hi_q[0]));
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        check_zero_outputs("in_reset");
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1 check_zero_outputs("after_reset");

        w0 = wr_seen;
        run(0, 110, -1, -1, -1);
        check("ramp_write_count", 32'(wr_seen - w0), 32'd64);

        run(0, 110, 40, -1, -1);
        run(0, 60, -1, 50, -1);
        run(0, 110, -1, -1, -1);
        run(0, 70, -1, -1, 60);
        w0 = wr_seen;
        run(0, 110, -1, -1, -1);
        check("post_reset_write_count", 32'(wr_seen - w0), 32'd64);

        // Back-to-back: second start lands in the DONE cycle of the first frame.
        run(0, 103, -1, -1, -1);
        run(0, 110, -1, -1, -1);

        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) img[r][c] = 8'd100;
        w0 = wr_seen;
        run(1, 110, -1, -1, -1);
        check("const_write_count", 32'(wr_seen - w0), 32'd64);

        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) img[r][c] = 8'd0;
        img[5][5] = 8'd255;
        run(1, 110, -1, -1, -1);

        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        check("leftover_writes", 32'(exp_q.size()), 32'd0);
        check("leftover_done",   32'(done_q.size()), 32'd0);
        check("leftover_err",    32'(err_q.size()),  32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
